muldiv_unit: RTL and testbench

//  Iterative RV32M/RV64M multiply/divide unit beside the single-cycle ALU in EX.

---
 rtl/muldiv_unit.sv | 173 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M/RV64M multiply/divide unit with valid/ready handshakes
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    localparam int CW = $clog2(XLEN);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state;
    logic [CW-1:0]   counter;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] divisor;
    logic            neg_res;
    logic            neg_rem;
    logic [2:0]      op_q;

    logic            m_op;
    logic            sgn_a;
    logic            sgn_b;
    logic            neg_a;
    logic            neg_b;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN-1:0] fast_result;

    always_comb begin
        m_op     = (ALUOp == 2'b10) && (Funct7 == 7'b0000001);
        sgn_a    = (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                   (Funct3 == 3'b100) || (Funct3 == 3'b110);
        sgn_b    = (Funct3 == 3'b001) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
        neg_a    = sgn_a && op_a[XLEN-1];
        neg_b    = sgn_b && op_b[XLEN-1];
        abs_a    = neg_a ? -op_a : op_a;
        abs_b    = neg_b ? -op_b : op_b;
        div_zero = Funct3[2] && (op_b == '0);
        div_ovf  = Funct3[2] && !Funct3[0] && (op_a == MIN_VAL) && (op_b == '1);
        fast_result = '0;
        if (div_zero) begin
            fast_result = Funct3[1] ? op_a : '1;
        end else if (div_ovf) begin
            fast_result = Funct3[1] ? '0 : MIN_VAL;
        end
    end

    // Multiply: lo holds the multiplier and shifts out LSB-first while the product grows into {hi,lo}.
    // Divide: lo holds the dividend, shifting out MSB-first while quotient bits shift in; hi is the remainder.
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic            div_ge;
    logic [XLEN-1:0] hi_next;
    logic [XLEN-1:0] lo_next;

    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, divisor} : '0);
        div_shift = {hi, lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, divisor};
        div_ge    = !div_diff[XLEN];
        if (op_q[2]) begin
            hi_next = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            lo_next = {lo[XLEN-2:0], div_ge};
        end else begin
            hi_next = mul_sum[XLEN:1];
            lo_next = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fix_result;

    always_comb begin
        prod = neg_res ? -{hi, lo} : {hi, lo};
        quo  = neg_res ? -lo : lo;
        rem  = neg_rem ? -hi : hi;
        case (op_q)
            3'b000:                 fix_result = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_result = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_result = quo;
            default:                fix_result = rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            counter <= '0;
            result  <= '0;
            illegal <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            divisor <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            op_q    <= '0;
        end else if (flush) begin
            state   <= S_IDLE;
            counter <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q <= Funct3;
                        if (!m_op) begin
                            result  <= '0;
                            illegal <= 1'b1;
                            state   <= S_DONE;
                        end else if (div_zero || div_ovf) begin
                            result  <= fast_result;
                            illegal <= 1'b0;
                            state   <= S_DONE;
                        end else begin
                            hi      <= '0;
                            lo      <= abs_a;
                            divisor <= abs_b;
                            neg_res <= neg_a ^ neg_b;
                            neg_rem <= neg_a;
                            counter <= '0;
                            state   <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    hi      <= hi_next;
                    lo      <= lo_next;
                    counter <= counter + CW'(1);
                    if (counter == CW'(XLEN-1)) begin
                        counter <= '0;
                        state   <= S_FIX;
                    end
                end
                S_FIX: begin
                    result  <= fix_result;
                    illegal <= 1'b0;
                    state   <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = reset_n && (state == S_IDLE);
    assign out_valid = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit against an arithmetic model
module tb_muldiv_unit;

    localparam int XLEN = 32;
    localparam logic [31:0] MIN_VAL = 32'h80000000;

    logic            clk;
    logic            reset_n;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      ALUOp;
    logic [6:0]      Funct7;
    logic [2:0]      Funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            illegal;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .Funct7(Funct7), .Funct3(Funct3), .op_a(op_a), .op_b(op_b),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] p;
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f3)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == MIN_VAL && b == 32'hFFFFFFFF) return MIN_VAL;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN_VAL && b == 32'hFFFFFFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [1:0] aluop, input logic [6:0] f7,
                          input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int hold);
        logic legal;
        logic fast;
        int   lat;
        int   exp_lat;
        legal   = (aluop == 2'b10) && (f7 == 7'b0000001);
        fast    = !legal || (f3[2] && (b == 0 || (!f3[0] && a == MIN_VAL && b == 32'hFFFFFFFF)));
        exp_lat = fast ? 0 : XLEN + 1;
        @(negedge clk);
        check({tag, ".rdy"}, 64'(in_ready), 64'(1));
        ALUOp = aluop; Funct7 = f7; Funct3 = f3; op_a = a; op_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".lat"}, 64'(lat), 64'(exp_lat));
        check({tag, ".res"}, 64'(result), 64'(exp_res));
        check({tag, ".ill"}, 64'(illegal), 64'(!legal));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, ".hold_res"}, 64'(result), 64'(exp_res));
            check({tag, ".hold_busy"}, 64'({out_valid, in_ready}), 64'(2'b10));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".idle"}, 64'({out_valid, in_ready}), 64'(2'b01));
    endtask

    task automatic abort_test(input bit use_reset);
        logic seen;
        @(negedge clk);
        ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'b100;
        op_a = 32'h12345678; op_b = 32'h00000111; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("abort.busy", 64'(in_ready), 64'(0));
        if (use_reset) reset_n = 1'b0;
        else flush = 1'b1;
        @(posedge clk); #1;
        if (use_reset) begin
            check("rst.outs", 64'({in_ready, out_valid, illegal, result}), 64'(0));
            reset_n = 1'b1;
        end else begin
            flush = 1'b0;
        end
        #1;
        check("abort.ready", 64'(in_ready), 64'(1));
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        check("abort.no_out", 64'(seen), 64'(0));
        run_op("abort.divu", 2'b10, 7'b0000001, 3'b101, 32'd9, 32'd3, 32'd3, 0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return MIN_VAL;
            2:       return 32'hFFFFFFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic        seen;
        logic [1:0]  aluop;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;

        reset_n = 1'b0; in_valid = 1'b0; ALUOp = 2'b00; Funct7 = 7'b0; Funct3 = 3'b0;
        op_a = '0; op_b = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.outs", 64'({in_ready, out_valid, illegal, result}), 64'(0));
        reset_n = 1'b1;

        run_op("mul",    2'b10, 7'b0000001, 3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 0);
        run_op("mulh",   2'b10, 7'b0000001, 3'b001, MIN_VAL,      MIN_VAL,      32'h40000000, 0);
        run_op("mulhu",  2'b10, 7'b0000001, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
        run_op("mulhsu", 2'b10, 7'b0000001, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op("div",    2'b10, 7'b0000001, 3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0);
        run_op("rem",    2'b10, 7'b0000001, 3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0);
        run_op("divu",   2'b10, 7'b0000001, 3'b101, 32'd100,      32'd7,        32'd14,       0);
        run_op("remu",   2'b10, 7'b0000001, 3'b111, 32'd100,      32'd7,        32'd2,        0);
        run_op("div0",   2'b10, 7'b0000001, 3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 0);
        run_op("remu0",  2'b10, 7'b0000001, 3'b111, 32'd5,        32'd0,        32'd5,        0);
        run_op("divovf", 2'b10, 7'b0000001, 3'b100, MIN_VAL,      32'hFFFFFFFF, MIN_VAL,      0);
        run_op("removf", 2'b10, 7'b0000001, 3'b110, MIN_VAL,      32'hFFFFFFFF, 32'h0,        0);
        run_op("illf7",  2'b10, 7'b0000000, 3'b000, 32'd3,        32'd4,        32'h0,        0);
        run_op("illop",  2'b00, 7'b0000001, 3'b101, 32'd3,        32'd4,        32'h0,        0);
        run_op("hold",   2'b10, 7'b0000001, 3'b101, 32'd1000,     32'd33,       32'd30,       5);
        run_op("next",   2'b10, 7'b0000001, 3'b000, 32'd12,       32'd12,       32'd144,      0);

        abort_test(1'b0);
        abort_test(1'b1);

        // Flush asserted alongside a request: nothing may be accepted.
        @(negedge clk);
        ALUOp = 2'b10; Funct7 = 7'b0000001; Funct3 = 3'b101; op_a = 32'd8; op_b = 32'd0;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        seen = out_valid;
        repeat (5) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        check("flush_accept.no_out", 64'({seen, in_ready}), 64'(2'b01));

        // Flush in DONE discards the pending result.
        @(negedge clk);
        ALUOp = 2'b01; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("flush_done.valid", 64'(out_valid), 64'(1));
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_done.drop", 64'({out_valid, in_ready}), 64'(2'b01));

        for (int i = 0; i < 250; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            aluop = 2'b10;
            f7    = 7'b0000001;
            if ($urandom_range(0, 15) == 0) begin
                if ($urandom_range(0, 1) == 0) aluop = 2'($urandom_range(0, 1));
                else f7 = 7'b0100000;
            end
            run_op("rnd", aluop, f7, f3, a, b,
                   (aluop == 2'b10 && f7 == 7'b0000001) ? ref_op(f3, a, b) : 32'h0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
